imm_gen_pipe: RTL and testbench

- Parametrised successor to the single-register immediate generator.
- Decodes RV32I/RV64I immediates from the fetched instruction and also classifies the immediate format, flags opcodes with no defined immediate handling, and handles shift-amount and CSR-zimm forms.
- Delivers the result through a configurable 1–2 stage pipeline with valid, stall and flush control.
- Sits between decode and execute; output feeds the ALU operand mux, branch target adder and CSR unit.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_decode.sv | 100 ++++++++++
 rtl/imm_gen_pipe.sv | 96 +++++++++
 tb/tb_imm_gen_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: opcodes, shift funct3 codes
// and the 3-bit immediate format codes reported on o_ImmType.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  localparam logic [1:0] QUAD_32BIT = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6,
    IMM_SH   = 3'd7
  } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder: instruction word in, extended
// immediate, format code and illegal flag out.
import imm_pkg::*;

module imm_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o,
  output logic            illegal_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  generate
    if (!(XLEN == 32 || XLEN == 64)) begin : gXlenCheck
      $error("imm_decode: XLEN must be 32 or 64");
    end
  endgenerate

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] raw32;
  logic        signExt;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Build each format as a 32-bit value (already sign-extended to 32 bits for
  // signed formats) and remember whether widening to XLEN must keep the sign.
  always_comb begin
    raw32     = '0;
    signExt   = 1'b0;
    type_o    = IMM_NONE;
    illegal_o = 1'b0;
    if (instr_i[1:0] != QUAD_32BIT) begin
      illegal_o = 1'b1;
    end else begin
      case (opcode)
        OPC_OP_IMM: begin
          if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) begin
            type_o = IMM_SH;
            raw32  = 32'(instr_i[20 +: SHAMT_W]);
          end else begin
            type_o  = IMM_I;
            raw32   = {{20{instr_i[31]}}, instr_i[31:20]};
            signExt = 1'b1;
          end
        end
        OPC_LOAD, OPC_JALR: begin
          type_o  = IMM_I;
          raw32   = {{20{instr_i[31]}}, instr_i[31:20]};
          signExt = 1'b1;
        end
        OPC_STORE: begin
          type_o  = IMM_S;
          raw32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
          signExt = 1'b1;
        end
        OPC_BRANCH: begin
          type_o  = IMM_B;
          raw32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
          signExt = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          type_o  = IMM_U;
          raw32   = {instr_i[31:12], 12'h000};
          signExt = 1'b1;
        end
        OPC_JAL: begin
          type_o  = IMM_J;
          raw32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
          signExt = 1'b1;
        end
        OPC_SYSTEM: begin
          if (funct3[2]) begin
            type_o = IMM_Z;
            raw32  = 32'(instr_i[19:15]);
          end else begin
            type_o  = IMM_I;
            raw32   = {{20{instr_i[31]}}, instr_i[31:20]};
            signExt = 1'b1;
          end
        end
        OPC_OP: begin
          type_o = IMM_NONE;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end
  end

  assign imm_o = signExt ? XLEN'($signed(raw32)) : XLEN'(raw32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 1-2 stage output pipeline. Stages are kept as
// flat shift vectors so one depth-agnostic shift covers both depths.
import imm_pkg::*;

module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     i_Instr,
  input  logic            i_Valid,
  input  logic            i_Stall,
  input  logic            i_Flush,
  output logic [XLEN-1:0] o_ImmE,
  output logic [2:0]      o_ImmType,
  output logic            o_ValidE,
  output logic            o_Illegal
);

  localparam int IMM_W  = STAGES * XLEN;
  localparam int TYPE_W = STAGES * 3;

  generate
    if (!(STAGES == 1 || STAGES == 2)) begin : gStagesCheck
      $error("imm_gen_pipe: STAGES must be 1 or 2");
    end
  endgenerate

  logic [XLEN-1:0] decImm;
  imm_type_e       decType;
  logic            decIllegal;

  logic [XLEN-1:0] inImm;
  logic [2:0]      inType;
  logic            inIllegal;

  logic [STAGES-1:0] validQ,   validD;
  logic [STAGES-1:0] illegalQ, illegalD;
  logic [IMM_W-1:0]  immQ,     immD;
  logic [TYPE_W-1:0] typeQ,    typeD;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (i_Instr),
    .imm_o     (decImm),
    .type_o    (decType),
    .illegal_o (decIllegal)
  );

  assign inImm     = i_Valid ? decImm : '0;
  assign inType    = i_Valid ? decType : IMM_NONE;
  assign inIllegal = i_Valid & decIllegal;

  // Next-state for the whole chain: flush zeroes everything, stall holds,
  // otherwise shift one stage toward the output with the new entry at stage 0.
  always_comb begin
    validD   = validQ;
    illegalD = illegalQ;
    immD     = immQ;
    typeD    = typeQ;
    if (i_Flush) begin
      validD   = '0;
      illegalD = '0;
      immD     = '0;
      typeD    = '0;
    end else if (!i_Stall) begin
      validD   = (validQ << 1) | STAGES'(i_Valid);
      illegalD = (illegalQ << 1) | STAGES'(inIllegal);
      immD     = (immQ << XLEN) | IMM_W'(inImm);
      typeD    = (typeQ << 3) | TYPE_W'(inType);
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ   <= '0;
      illegalQ <= '0;
      immQ     <= '0;
      typeQ    <= '0;
    end else begin
      validQ   <= validD;
      illegalQ <= illegalD;
      immQ     <= immD;
      typeQ    <= typeD;
    end
  end

  assign o_ValidE  = validQ[STAGES-1];
  assign o_Illegal = illegalQ[STAGES-1];
  assign o_ImmE    = immQ[IMM_W-1 -: XLEN];
  assign o_ImmType = typeQ[TYPE_W-1 -: 3];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench driving a 32-bit/1-stage and a 64-bit/2-stage instance
// from the same stimulus and checking both against a reference decoder.
module tb_imm_gen_pipe;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] imm32;
  logic [2:0]  type32;
  logic        valid32, ill32;
  logic [63:0] imm64;
  logic [2:0]  type64;
  logic        valid64, ill64;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   advCount = 0;
  int   total    = 0;
  int   bad      = 0;

  exp_t cur32, cur64;
  logic have32 = 1'b0;
  logic have64 = 1'b0;
  int   seenAdv = -1;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_Instr   (instr),
    .i_Valid   (valid),
    .i_Stall   (stall),
    .i_Flush   (flush),
    .o_ImmE    (imm32),
    .o_ImmType (type32),
    .o_ValidE  (valid32),
    .o_Illegal (ill32)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_Instr   (instr),
    .i_Valid   (valid),
    .i_Stall   (stall),
    .i_Flush   (flush),
    .o_ImmE    (imm64),
    .o_ImmType (type64),
    .o_ValidE  (valid64),
    .o_Illegal (ill64)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic longint sx(input longint unsigned val, input int bits);
    if (val >= (64'd1 << (bits - 1)))
      return longint'(val) - (longint'(1) << bits);
    return longint'(val);
  endfunction

  // Reference decoder: pulls each field out with shifts and masks, then
  // applies two's-complement sign extension arithmetically.
  function automatic exp_t refDecode(input logic [31:0] ins, input int xlen);
    exp_t            e;
    longint          v;
    longint unsigned w;
    logic [6:0]      op;
    logic [2:0]      f3;
    w  = 64'(ins);
    op = ins[6:0];
    f3 = ins[14:12];
    v  = 0;
    e.typ = 3'd0;
    e.ill = 1'b0;
    e.due = 0;
    if (ins[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (op)
        7'b0010011: begin
          if (f3 == 3'd1 || f3 == 3'd5) begin
            e.typ = 3'd7;
            v = longint'((w >> 20) & longint'(xlen - 1));
          end else begin
            e.typ = 3'd1;
            v = sx((w >> 20) & 64'hFFF, 12);
          end
        end
        7'b0000011, 7'b1100111: begin
          e.typ = 3'd1;
          v = sx((w >> 20) & 64'hFFF, 12);
        end
        7'b0100011: begin
          e.typ = 3'd2;
          v = sx(((w >> 25) << 5) | ((w >> 7) & 31), 12);
        end
        7'b1100011: begin
          e.typ = 3'd3;
          v = sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                 (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
        end
        7'b0110111, 7'b0010111: begin
          e.typ = 3'd4;
          v = sx(w & 64'hFFFFF000, 32);
        end
        7'b1101111: begin
          e.typ = 3'd5;
          v = sx((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                 (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
        end
        7'b1110011: begin
          if (f3 >= 3'd4) begin
            e.typ = 3'd6;
            v = longint'((w >> 15) & 31);
          end else begin
            e.typ = 3'd1;
            v = sx((w >> 20) & 64'hFFF, 12);
          end
        end
        7'b0110011: begin
          e.typ = 3'd0;
        end
        default: begin
          e.ill = 1'b1;
        end
      endcase
    end
    e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops [12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b1110011, 7'b0110011, 7'b0101111, 7'b0001111};
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic v, input logic [63:0] imm,
                             input logic [2:0] t, input logic il, input logic ev,
                             input logic [63:0] eImm, input logic [2:0] eT, input logic eIl);
    total++;
    if ({v, imm, t, il} !== {ev, eImm, eT, eIl}) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got valid=%0b imm=%h type=%0d ill=%0b, want valid=%0b imm=%h type=%0d ill=%0b",
               tag, $time, v, imm, t, il, ev, eImm, eT, eIl);
    end
  endtask

  // Drive one cycle of inputs, then record what the pipeline should do at
  // the rising edge that consumes them.
  task automatic applyStimulus(input logic [31:0] ins, input logic v,
                               input logic st, input logic fl);
    exp_t e;
    instr = ins;
    valid = v;
    stall = st;
    flush = fl;
    @(posedge clk);
    if (fl) begin
      q32.delete();
      q64.delete();
      advCount++;
    end else if (!st) begin
      advCount++;
      if (v) begin
        e = refDecode(ins, 32);
        e.due = advCount;
        q32.push_back(e);
        e = refDecode(ins, 64);
        e.due = advCount + 1;
        q64.push_back(e);
      end
    end
    #2;
  endtask

  // Monitor: after every pipeline movement, pick up the entry due at the
  // output (if any) and compare both instances on each falling edge.
  always @(negedge clk) begin
    if (advCount != seenAdv) begin
      seenAdv = advCount;
      have32  = 1'b0;
      have64  = 1'b0;
      if (q32.size() > 0 && q32[0].due == advCount) begin
        cur32  = q32.pop_front();
        have32 = 1'b1;
      end
      if (q64.size() > 0 && q64[0].due == advCount) begin
        cur64  = q64.pop_front();
        have64 = 1'b1;
      end
    end
    checkOutput("out32", valid32, {32'h0, imm32}, type32, ill32, have32,
                have32 ? cur32.imm : 64'h0, have32 ? cur32.typ : 3'd0,
                have32 ? cur32.ill : 1'b0);
    checkOutput("out64", valid64, imm64, type64, ill64, have64,
                have64 ? cur64.imm : 64'h0, have64 ? cur64.typ : 3'd0,
                have64 ? cur64.ill : 1'b0);
  end

  // Main sequence: reset, directed vectors, stall/flush cases, random
  // traffic, then an asynchronous reset while results are live.
  initial begin
    logic [31:0] directed [14] = '{32'h00500113, 32'hFF718393, 32'h02728863,
                                   32'h0471AA23, 32'h008001EF, 32'h4032D293,
                                   32'h123452B7, 32'h004282B3, 32'h00000000,
                                   32'hFEDCB2B7, 32'h03F29293, 32'h3050D073,
                                   32'h00000073, 32'hFFF00067};
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset32", valid32, {32'h0, imm32}, type32, ill32, 1'b0, 64'h0, 3'd0, 1'b0);
    checkOutput("reset64", valid64, imm64, type64, ill64, 1'b0, 64'h0, 3'd0, 1'b0);
    #20 rst_n = 1'b1;

    foreach (directed[i]) applyStimulus(directed[i], 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(32'h00100093, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hFE208EE3, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h00C12023, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h800000B7, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h800000B7, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h800000B7, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(32'h00500113, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h008001EF, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0471AA23, 1'b1, 1'b1, 1'b1);
    applyStimulus(32'h02728863, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h123452B7, 1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(randInstr(), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    repeat (3) applyStimulus(randInstr(), 1'b1, 1'b0, 1'b0);
    total++;
    if (!(valid32 === 1'b1 && valid64 === 1'b1)) begin
      bad++;
      $display("[TB] FAIL preResetValid: got valid32=%0b valid64=%0b, want 1 1", valid32, valid64);
    end
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    checkOutput("asyncRst32", valid32, {32'h0, imm32}, type32, ill32, 1'b0, 64'h0, 3'd0, 1'b0);
    checkOutput("asyncRst64", valid64, imm64, type64, ill64, 1'b0, 64'h0, 3'd0, 1'b0);
    q32.delete();
    q64.delete();
    advCount++;
    #10 rst_n = 1'b1;

    repeat (4) applyStimulus(randInstr(), 1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (q32.size() + q64.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover: got %0d undelivered entries, want 0", q32.size() + q64.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
